// File: rtl/bcd_seq_if.sv
// rtl/bcd_seq_if.sv - handshake and result bundle for the sequential binary-to-BCD converter
interface bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_seq.sv
// rtl/bcd_seq.sv - one-bit-per-clock double-dabble converter with overflow detect and optional saturation
module bcd_seq #(
  parameter int BIN_W    = 8,
  parameter int DIGITS   = 3,
  parameter int SATURATE = 1
) (
  input logic       clk,
  input logic       reset_n,
  bcd_seq_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, sr_nx, adj;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ovf_pend, ovf_pend_nx;
  logic [BCD_W-1:0]  bcd_q, bcd_nx;
  logic              ovf_q, ovf_nx;
  logic              done_q, done_nx;

  // Add-3 correction on pre-shift digit values; no carry between digits.
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    cnt_nx      = cnt;
    ovf_pend_nx = ovf_pend;
    bcd_nx      = bcd_q;
    ovf_nx      = ovf_q;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sr_nx       = {{BCD_W{1'b0}}, bus.bin};
          cnt_nx      = CNT_W'(BIN_W);
          ovf_pend_nx = 1'b0;
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx  = {adj[SR_W-2:0], 1'b0};
        cnt_nx = cnt - CNT_W'(1);
        if (adj[SR_W-1])
          ovf_pend_nx = 1'b1;
        if (cnt == CNT_W'(1))
          state_nx = DONE;
      end
      DONE: begin
        if (ovf_pend && (SATURATE != 0))
          bcd_nx = {DIGITS{4'h9}};
        else
          bcd_nx = sr[SR_W-1 -: BCD_W];
        ovf_nx   = ovf_pend;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      cnt      <= cnt_nx;
      ovf_pend <= ovf_pend_nx;
      bcd_q    <= bcd_nx;
      ovf_q    <= ovf_nx;
      done_q   <= done_nx;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bcd_seq.sv
// tb/tb_bcd_seq.sv - directed scoreboard bench over four parameterisations of bcd_seq
module tb_bcd_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        st [4];
  logic [15:0] bn [4];
  logic        done_w [4];
  logic        busy_w [4];
  logic        ovf_w  [4];
  logic [19:0] bcd_w  [4];
  int          done_cnt [4];

  bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if0 ();
  bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if1 ();
  bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if2 ();
  bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if3 ();

  bcd_seq #(.BIN_W(8),  .DIGITS(3), .SATURATE(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  bcd_seq #(.BIN_W(16), .DIGITS(5), .SATURATE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  bcd_seq #(.BIN_W(8),  .DIGITS(2), .SATURATE(1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  bcd_seq #(.BIN_W(8),  .DIGITS(2), .SATURATE(0)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

  assign if0.start = st[0];  assign if0.bin = bn[0][7:0];
  assign if1.start = st[1];  assign if1.bin = bn[1];
  assign if2.start = st[2];  assign if2.bin = bn[2][7:0];
  assign if3.start = st[3];  assign if3.bin = bn[3][7:0];

  assign done_w[0] = if0.done;  assign busy_w[0] = if0.busy;  assign ovf_w[0] = if0.overflow;  assign bcd_w[0] = 20'(if0.bcd);
  assign done_w[1] = if1.done;  assign busy_w[1] = if1.busy;  assign ovf_w[1] = if1.overflow;  assign bcd_w[1] = 20'(if1.bcd);
  assign done_w[2] = if2.done;  assign busy_w[2] = if2.busy;  assign ovf_w[2] = if2.overflow;  assign bcd_w[2] = 20'(if2.bcd);
  assign done_w[3] = if3.done;  assign busy_w[3] = if3.busy;  assign ovf_w[3] = if3.overflow;  assign bcd_w[3] = 20'(if3.bcd);

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;

  typedef struct {
    int          k;
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;
  exp_t sb [$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference result from plain decimal arithmetic.
  function automatic exp_t model(input int k, input int v);
    exp_t e;
    int d, lim, r;
    bit sat;
    d   = (k == 0) ? 3 : (k == 1) ? 5 : 2;
    sat = (k != 3);
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.k   = k;
    e.ovf = (v >= lim);
    e.bcd = '0;
    r = v % lim;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = (e.ovf && sat) ? 4'h9 : 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  task automatic go(input int k, input int v, input bit push);
    st[k] = 1'b1;
    bn[k] = 16'(v);
    if (push) sb.push_back(model(k, v));
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int exp_n, input string tag);
    int n = 0;
    int bc = 0;
    bit got = 0;
    exp_t e;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      got = (done_w[k] === 1'b1);
      if (!got && busy_w[k] === 1'b1) bc++;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_n - 1));
      chk({tag, "_busy_at_done"}, 32'(busy_w[k]), 32'd0);
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_inst"}, 32'(k), 32'(e.k));
        chk({tag, "_bcd"}, 32'(bcd_w[k]), 32'(e.bcd));
        chk({tag, "_ovf"}, 32'(ovf_w[k]), 32'(e.ovf));
      end
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 4; i++) begin
      st[i] = 1'b0;
      bn[i] = '0;
      done_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("rst_bcd%0d", i), 32'(bcd_w[i]), 32'd0);
      chk($sformatf("rst_ovf%0d", i), 32'(ovf_w[i]), 32'd0);
    end

    go(0, 255, 1);
    wait_done(0, 9, "d255");
    @(negedge clk);
    chk("done_one_cycle", 32'(done_w[0]), 32'd0);

    // Back-to-back with start held high through the done cycle.
    st[0] = 1'b1;
    bn[0] = 16'd0;
    sb.push_back(model(0, 0));
    @(negedge clk);
    bn[0] = 16'd137;
    sb.push_back(model(0, 137));
    wait_done(0, 9, "b2b_0");
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 9, "b2b_137");

    go(1, 65535, 1);
    wait_done(1, 17, "w16_65535");

    go(2, 150, 1);
    wait_done(2, 9, "sat_150");
    go(3, 150, 1);
    wait_done(3, 9, "trunc_150");
    go(2, 42, 1);
    wait_done(2, 9, "sat_42");
    go(3, 42, 1);
    wait_done(3, 9, "trunc_42");

    // Start during busy must be ignored.
    d0 = done_cnt[0];
    go(0, 200, 1);
    repeat (2) @(negedge clk);
    go(0, 7, 0);
    wait_done(0, 6, "ignore");
    repeat (12) @(negedge clk);
    chk("ignore_single_done", 32'(done_cnt[0] - d0), 32'd1);
    chk("ignore_no_restart", 32'(busy_w[0]), 32'd0);

    // Reset mid-conversion aborts without a done pulse.
    go(0, 99, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt[0];
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_bcd", 32'(bcd_w[0]), 32'd0);
    chk("abort_ovf", 32'(ovf_w[0]), 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    chk("abort_bcd_hold", 32'(bcd_w[0]), 32'd0);
    go(0, 99, 1);
    wait_done(0, 9, "after_abort_99");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
